// File: rtl/tree_psum_accumulator.sv
// Accumulates per-cycle adder-tree sums into dot-product results and queues them
// in a small output FIFO. A credit counter throttles tile issue so the FIFO never overflows.
module tree_psum_accumulator #(
    parameter int NUM_MAC      = 256,
    parameter int WORD_SIZE    = 8,
    parameter int TREE_LATENCY = 9,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic [2*WORD_SIZE-1:0]   tree_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_data
);

    localparam int SUM_WIDTH = 2 * WORD_SIZE;
    localparam int CNT_WIDTH = $clog2(OUT_DEPTH + 1);
    localparam int PTR_WIDTH = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    // Reject parameter sets the datapath cannot honour.
    if (TREE_LATENCY < 1) begin : g_bad_latency
        $error("TREE_LATENCY must be >= 1");
    end
    if (ACC_WIDTH < SUM_WIDTH) begin : g_bad_acc_width
        $error("ACC_WIDTH must be >= 2*WORD_SIZE");
    end
    if (OUT_DEPTH < 1) begin : g_bad_depth
        $error("OUT_DEPTH must be >= 1");
    end
    if (NUM_MAC < 1 || (NUM_MAC & (NUM_MAC - 1)) != 0) begin : g_bad_num_mac
        $error("NUM_MAC must be a power of two");
    end

    logic                    accept;
    logic                    pop;
    logic                    push;
    logic [CNT_WIDTH-1:0]    pending;
    logic [TREE_LATENCY-1:0] dv_pipe;
    logic [TREE_LATENCY-1:0] dl_pipe;
    logic                    dv;
    logic                    dl;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    first;
    logic [ACC_WIDTH-1:0]    sum;
    logic [ACC_WIDTH-1:0]    mem [OUT_DEPTH];
    logic [PTR_WIDTH-1:0]    wr_ptr;
    logic [PTR_WIDTH-1:0]    rd_ptr;
    logic [CNT_WIDTH-1:0]    count;
    logic                    full;

    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(OUT_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign in_ready  = (pending < CNT_WIDTH'(OUT_DEPTH));
    assign accept    = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign full      = (count == CNT_WIDTH'(OUT_DEPTH));
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    assign dv   = dv_pipe[TREE_LATENCY-1];
    assign dl   = dl_pipe[TREE_LATENCY-1];
    assign push = dv & dl;

    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        sum = '0;
        if (!first) begin
            sum = acc;
        end
        sum = sum + ACC_WIDTH'(tree_sum);
    end

    // A credit is taken when a dot product is issued, not when its result lands,
    // so every in-flight product already owns a FIFO slot.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            case ({accept & in_last, pop})
                2'b10:   pending <= pending + CNT_WIDTH'(1);
                2'b01:   pending <= pending - CNT_WIDTH'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Tile tracking through the fixed tree latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_pipe <= '0;
            dl_pipe <= '0;
        end else begin
            dv_pipe[0] <= accept;
            dl_pipe[0] <= accept & in_last;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                dv_pipe[i] <= dv_pipe[i-1];
                dl_pipe[i] <= dl_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            first <= 1'b1;
        end else if (dv) begin
            if (dl) begin
                acc   <= '0;
                first <= 1'b1;
            end else begin
                acc   <= sum;
                first <= 1'b0;
            end
        end
    end

    // NOTE: the FIFO storage is reset because out_data reads it directly and must be 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sum;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // The credit counter makes an overflowing push unreachable.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_tree_psum_accumulator.sv
// Scoreboard bench for tree_psum_accumulator: a model of the upstream tree drives
// tree_sum at the right latency, and expected results are queued at issue time.
module tb_tree_psum_accumulator;

    localparam int L = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] tree_sum = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    logic        w_valid = 1'b0;
    logic        w_last = 1'b0;
    logic        w_ready;
    logic [15:0] w_sum = '0;
    logic        w_out_valid;
    logic [15:0] w_out_data;

    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    logic [15:0] sched [int];
    logic [31:0] exp_q [$];
    logic [31:0] acc_m = '0;

    tree_psum_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    tree_psum_accumulator #(.ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_last(w_last), .in_ready(w_ready),
        .tree_sum(w_sum), .out_valid(w_out_valid), .out_ready(1'b0), .out_data(w_out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Upstream tree model: scheduled sums land on their edge, otherwise garbage.
    always @(posedge clk) begin
        #1;
        if (sched.exists(edge_cnt)) tree_sum = sched[edge_cnt];
        else tree_sum = 16'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_result", 32'(exp_q.size()), 32'd1);
            else check("result", out_data, exp_q.pop_front());
        end
    end

    // Presents one tile for one cycle; called #1 after a rising edge.
    task automatic drive_tile(input logic last, input logic [15:0] s, output bit accepted);
        in_valid = 1'b1;
        in_last  = last;
        accepted = in_ready;
        if (accepted) begin
            sched[edge_cnt + L] = s;
            acc_m = acc_m + 32'(s);
            if (last) begin
                exp_q.push_back(acc_m);
                acc_m = '0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        tick(1);
        check("drained", 32'(exp_q.size()), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit a;
        bit seen;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single tile with exact latency.
        out_ready = 1'b1;
        drive_tile(1'b1, 16'h1234, a);
        check("single_accept", 32'(a), 32'd1);
        tick(L - 1);
        check("single_early", 32'(out_valid), 32'd0);
        tick(1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", out_data, 32'h1234);
        tick(1);
        check("single_popped", 32'(out_valid), 32'd0);

        // Three-tile dot product back to back.
        drive_tile(1'b0, 16'h0100, a);
        drive_tile(1'b0, 16'h0200, a);
        drive_tile(1'b1, 16'h0300, a);
        drain();

        // Back-to-back products with no bubble between them.
        for (int i = 0; i < 6; i++) drive_tile(i[0], 16'(16'h0040 + i), a);
        drain();

        // Back-pressure with the FIFO held.
        out_ready = 1'b0;
        drive_tile(1'b1, 16'h000a, a);
        drive_tile(1'b1, 16'h000b, a);
        drive_tile(1'b1, 16'h000c, a);
        drive_tile(1'b1, 16'h000d, a);
        check("bp_not_ready", 32'(in_ready), 32'd0);
        drive_tile(1'b1, 16'h0eee, a);
        check("bp_ignored", 32'(a), 32'd0);
        tick(L + 3);
        check("bp_head_valid", 32'(out_valid), 32'd1);
        check("bp_head_data", out_data, exp_q[0]);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("bp_ready_again", 32'(in_ready), 32'd1);
        check("bp_remaining", 32'(exp_q.size()), 32'd3);
        tick(2);
        check("bp_head_stable", out_data, exp_q[0]);
        drain();

        // Idle cycles with garbage tree sums inside one product.
        drive_tile(1'b0, 16'h0011, a);
        tick(3);
        drive_tile(1'b1, 16'h0022, a);
        drain();

        // Accumulator wrap on a 16-bit instance.
        w_valid = 1'b1;
        tick(1);
        w_last = 1'b1;
        tick(1);
        w_valid = 1'b0;
        w_last  = 1'b0;
        tick(L - 2);
        w_sum = 16'hffff;
        tick(1);
        w_sum = 16'h0002;
        tick(1);
        w_sum = 16'h5a5a;
        check("wrap_valid", 32'(w_out_valid), 32'd1);
        check("wrap_data", 32'(w_out_data), 32'h0001);

        // Reset while a last tile is in flight.
        out_ready = 1'b1;
        drive_tile(1'b1, 16'h0777, a);
        tick(5);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_w_valid", 32'(w_out_valid), 32'd0);
        exp_q.delete();
        sched.delete();
        acc_m = '0;
        tick(1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * L; i++) begin
            if (out_valid) seen = 1'b1;
            tick(1);
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);

        // Normal operation resumes after reset.
        drive_tile(1'b1, 16'h0abc, a);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
